nlfsr_tap_enumerator: RTL and testbench
=======================================

// Module: nlfsr_tap_enumerator
// PURPOSE
//  Upstream driver for the NLFSR period checker. Walks every tap-set candidate as an odometer and drives it on co_buf.
//  Resets and enables the checker for each candidate, then waits for found/failure.
//  Found candidates are reported on a valid/ready result port. Asserts done when the whole space is exhausted.
// PARAMETERS
//  SIZE         11               NLFSR length; tap values range TAP_MIN..SIZE-1
//  NUM_OF_TAPS  6                taps per candidate; co_buf is NUM_OF_TAPS bytes
//  TAP_MIN      1                lowest legal tap value
//  RST_CYCLES   2                cycles nlfsr_res is held per candidate (>=1)
//  CNT_W        32               width of cand_count and found_count
//  TIMEOUT_CYC  (1<<SIZE)+16     watchdog limit per candidate (TIMEOUT_EN only)
// PORTS
//  clk          in   1               clock, posedge
//  res          in   1               reset, asynchronous, active-high
//  ena          in   1               global enable; 0 freezes the FSM and all counters
//  start        in   1               1-cycle pulse; starts a sweep from IDLE or DONE
//  co_buf       out  NUM_OF_TAPS*8   current candidate; byte k = tap k; byte 0 in [7:0]
//  nlfsr_res    out  1               reset to the checker
//  nlfsr_ena    out  1               enable to the checker
//  found        in   1               checker reports maximal period
//  failure      in   1               checker reports non-maximal period
//  res_valid    out  1               found candidate is available on res_taps
//  res_taps     out  NUM_OF_TAPS*8   taps of the found candidate
//  res_ready    in   1               consumer accepts res_taps
//  busy         out  1               sweep in progress
//  done         out  1               sweep complete; sticky until the next start or reset
//  cand_count   out  CNT_W           number of candidates evaluated
//  found_count  out  CNT_W           number of candidates found
// BEHAVIOUR
//  Reset values: every tap byte = TAP_MIN, nlfsr_res=1, nlfsr_ena=0, res_valid=0, res_taps=0, busy=0, done=0, counts=0. State = IDLE.
//  States:
//   IDLE: nlfsr_res=1. On start -> LOAD; candidate and counts are cleared to the reset values.
//   LOAD: nlfsr_res=1 for exactly RST_CYCLES cycles -> RUN.
//   RUN: nlfsr_res=0 and nlfsr_ena=1 (while ena=1).
//    - found=1 -> REPORT. found has priority over a simultaneous failure.
//    - failure=1 -> NEXT.
//    - Otherwise stay in RUN.
//   REPORT: nlfsr_ena=0. res_valid=1 and res_taps=co_buf until the cycle res_valid&&res_ready. That cycle: found_count++ -> NEXT.
//   NEXT: cand_count++ and the odometer steps.
//    - Step rule: byte 0 +1; a byte at SIZE-1 wraps to TAP_MIN and carries to the next byte.
//    - Carry out of the top byte -> DONE; co_buf keeps the final candidate (all bytes SIZE-1).
//    - Otherwise -> LOAD.
//   DONE: nlfsr_res=1, busy=0, done=1. start -> LOAD with a fresh sweep.
//  busy=1 in LOAD/RUN/REPORT/NEXT. start while busy is ignored.
//  Candidate space = (SIZE-TAP_MIN)^NUM_OF_TAPS. cand_count saturates at all-ones.
//  The first candidate is in nlfsr_res one cycle after start. Each candidate costs RST_CYCLES+run+1 cycles (+ handshake if found).
//  found/failure are sampled only in RUN. Pulses in any other state are ignored.
//  ena=0: state, timers and outputs hold, except nlfsr_ena is forced to 0. An ena=0 cycle is not a run cycle.
//  res asserted mid-sweep: everything returns to the reset values immediately. A pending result is lost.
// CONFIGURATION
//  TIMEOUT_EN defined:
//   - RUN counts cycles. Reaching TIMEOUT_CYC with neither found nor failure is treated as failure -> NEXT.
//   - The timeout also increments timeout_count (extra output, CNT_W, reset 0).
//   - A found or failure arriving in the same cycle as the timeout wins over it.
//  TIMEOUT_EN undefined: no watchdog, no timeout_count port. RUN waits indefinitely.
// STRUCTURE
//  Package nlfsr_pkg:
//   - TAP_W=8.
//   - State enum: IDLE, LOAD, RUN, REPORT, NEXT, DONE.
//   - Function computing candidate-space size, for the bench.
//  Sub-module tap_odometer:
//   - Params: NUM_OF_TAPS, SIZE, TAP_MIN.
//   - Ports: clk, res, clr, step, taps, wrap.
//   - Ripple-carry digit counter. wrap is combinational, high when step would overflow.
// TESTING (SIZE=4, NUM_OF_TAPS=2, TAP_MIN=1, RST_CYCLES=2; 9 candidates)
//  Reset then start, checker model always returns failure 3 cycles into RUN:
//   -> co_buf sequence 16'h0101,0102,0103,0201,...,0303.
//   -> done=1, cand_count=9, found_count=0, res_valid never high.
//  Model returns found only for taps 16'h0203, res_ready tied 1:
//   -> exactly one res_valid pulse with res_taps=16'h0203. found_count=1.
//  Same as above but res_ready held 0 for 20 cycles:
//   -> res_valid and res_taps stable for all 21 cycles. nlfsr_ena=0 throughout. No step until accept.
//  found and failure asserted together in RUN -> treated as found (REPORT entered).
//  ena dropped for 5 cycles in RUN, and start pulsed while busy:
//   -> state frozen, nlfsr_ena=0, counts unchanged. start has no effect.
//  res asserted during candidate 16'h0202:
//   -> co_buf=16'h0101, counts=0, idle. Next start resumes at 16'h0101.
//  With TIMEOUT_EN and TIMEOUT_CYC=32, model never responds:
//   -> each candidate advances after 32 RUN cycles. timeout_count=9 at done.

Source files
------------

// File: rtl/nlfsr_pkg.sv
// Shared types and helpers for the NLFSR tap-set enumerator.
package nlfsr_pkg;

    localparam int TAP_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        REPORT,
        NEXT,
        DONE
    } state_t;

    function automatic int cand_space(
        input int size,
        input int ntaps,
        input int tap_min
    );
        int n;
        n = 1;
        for (int i = 0; i < ntaps; i++) begin
            n = n * (size - tap_min);
        end
        return n;
    endfunction

endpackage

// File: rtl/tap_odometer.sv
// Ripple-carry digit counter over tap bytes TAP_MIN..SIZE-1.
module tap_odometer
    import nlfsr_pkg::*;
#(
    parameter int NUM_OF_TAPS = 6,
    parameter int SIZE        = 11,
    parameter int TAP_MIN     = 1
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         clr,
    input  logic                         step,
    output logic [NUM_OF_TAPS*TAP_W-1:0] taps,
    output logic                         wrap
);

    localparam logic [TAP_W-1:0] T_MAX = TAP_W'(SIZE - 1);
    localparam logic [TAP_W-1:0] T_MIN = TAP_W'(TAP_MIN);

    logic [NUM_OF_TAPS-1:0]       at_max;
    logic [NUM_OF_TAPS*TAP_W-1:0] nxt;

    always_comb begin
        at_max = '0;
        for (int k = 0; k < NUM_OF_TAPS; k++) begin
            at_max[k] = (taps[k*TAP_W +: TAP_W] == T_MAX);
        end
    end

    assign wrap = &at_max;

    always_comb begin
        logic run;
        run = 1'b1;
        nxt = taps;
        for (int k = 0; k < NUM_OF_TAPS; k++) begin
            if (run) begin
                nxt[k*TAP_W +: TAP_W] = at_max[k] ? T_MIN
                                      : taps[k*TAP_W +: TAP_W] + 1'b1;
            end
            run = run & at_max[k];
        end
    end

    // On overflow the final candidate is kept rather than wrapping.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            taps <= {NUM_OF_TAPS{T_MIN}};
        end else if (clr) begin
            taps <= {NUM_OF_TAPS{T_MIN}};
        end else if (step && !wrap) begin
            taps <= nxt;
        end
    end

endmodule

// File: rtl/nlfsr_tap_enumerator.sv
// Sweeps every tap-set candidate through the NLFSR period checker.
// Define TIMEOUT_EN to add a per-candidate RUN watchdog and timeout_count.
module nlfsr_tap_enumerator
    import nlfsr_pkg::*;
#(
    parameter int SIZE        = 11,
    parameter int NUM_OF_TAPS = 6,
    parameter int TAP_MIN     = 1,
    parameter int RST_CYCLES  = 2,
    parameter int CNT_W       = 32
`ifdef TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = (1 << SIZE) + 16
`endif
) (
    input  logic                         clk,
    input  logic                         res,
    input  logic                         ena,
    input  logic                         start,
    output logic [NUM_OF_TAPS*TAP_W-1:0] co_buf,
    output logic                         nlfsr_res,
    output logic                         nlfsr_ena,
    input  logic                         found,
    input  logic                         failure,
    output logic                         res_valid,
    output logic [NUM_OF_TAPS*TAP_W-1:0] res_taps,
    input  logic                         res_ready,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             cand_count,
    output logic [CNT_W-1:0]             found_count
`ifdef TIMEOUT_EN
    ,
    output logic [CNT_W-1:0]             timeout_count
`endif
);

    localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t         state;
    logic [RCW-1:0] rst_cnt;
    logic           odo_clr;
    logic           odo_step;
    logic           odo_wrap;

`ifdef TIMEOUT_EN
    localparam int TCW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TCW-1:0] run_cnt;
`endif

    assign odo_clr  = ena && start && (state == IDLE || state == DONE);
    assign odo_step = ena && (state == NEXT);

    // The checker only runs on cycles the global enable lets through.
    assign nlfsr_ena = ena && (state == RUN);

    tap_odometer #(
        .NUM_OF_TAPS(NUM_OF_TAPS),
        .SIZE       (SIZE),
        .TAP_MIN    (TAP_MIN)
    ) u_odo (
        .clk (clk),
        .res (res),
        .clr (odo_clr),
        .step(odo_step),
        .taps(co_buf),
        .wrap(odo_wrap)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state       <= IDLE;
            rst_cnt     <= '0;
            nlfsr_res   <= 1'b1;
            res_valid   <= 1'b0;
            res_taps    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            cand_count  <= '0;
            found_count <= '0;
`ifdef TIMEOUT_EN
            run_cnt       <= '0;
            timeout_count <= '0;
`endif
        end else if (ena) begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= LOAD;
                        rst_cnt     <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        cand_count  <= '0;
                        found_count <= '0;
`ifdef TIMEOUT_EN
                        timeout_count <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
                        state     <= RUN;
                        nlfsr_res <= 1'b0;
`ifdef TIMEOUT_EN
                        run_cnt   <= '0;
`endif
                    end else begin
                        rst_cnt <= rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (found) begin
                        state     <= REPORT;
                        nlfsr_res <= 1'b1;
                        res_valid <= 1'b1;
                        res_taps  <= co_buf;
                    end else if (failure) begin
                        state     <= NEXT;
                        nlfsr_res <= 1'b1;
                    end
`ifdef TIMEOUT_EN
                    else if (run_cnt == TCW'(TIMEOUT_CYC - 1)) begin
                        state         <= NEXT;
                        nlfsr_res     <= 1'b1;
                        timeout_count <= timeout_count + 1'b1;
                    end else begin
                        run_cnt <= run_cnt + 1'b1;
                    end
`endif
                end
                REPORT: begin
                    if (res_ready) begin
                        state       <= NEXT;
                        res_valid   <= 1'b0;
                        found_count <= found_count + 1'b1;
                    end
                end
                NEXT: begin
                    if (~&cand_count) begin
                        cand_count <= cand_count + 1'b1;
                    end
                    if (odo_wrap) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state   <= LOAD;
                        rst_cnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nlfsr_tap_enumerator.sv
// Scoreboard bench for nlfsr_tap_enumerator with a behavioural checker model.
module tb_nlfsr_tap_enumerator;
    import nlfsr_pkg::*;

    localparam int SIZE = 4;
    localparam int NT   = 2;
    localparam int TMIN = 1;
    localparam int RSTC = 2;
    localparam int CW   = 32;
    localparam int W    = NT * 8;
    localparam int R    = SIZE - TMIN;
    localparam int NC   = cand_space(SIZE, NT, TMIN);

    logic          clk;
    logic          res;
    logic          ena;
    logic          start;
    logic [W-1:0]  co_buf;
    logic          nlfsr_res;
    logic          nlfsr_ena;
    logic          found;
    logic          failure;
    logic          res_valid;
    logic [W-1:0]  res_taps;
    logic          res_ready;
    logic          busy;
    logic          done;
    logic [CW-1:0] cand_count;
    logic [CW-1:0] found_count;
`ifdef TIMEOUT_EN
    logic [CW-1:0] timeout_count;
`endif

    nlfsr_tap_enumerator #(
        .SIZE       (SIZE),
        .NUM_OF_TAPS(NT),
        .TAP_MIN    (TMIN),
        .RST_CYCLES (RSTC),
        .CNT_W      (CW)
`ifdef TIMEOUT_EN
        ,
        .TIMEOUT_CYC(32)
`endif
    ) dut (
        .clk        (clk),
        .res        (res),
        .ena        (ena),
        .start      (start),
        .co_buf     (co_buf),
        .nlfsr_res  (nlfsr_res),
        .nlfsr_ena  (nlfsr_ena),
        .found      (found),
        .failure    (failure),
        .res_valid  (res_valid),
        .res_taps   (res_taps),
        .res_ready  (res_ready),
        .busy       (busy),
        .done       (done),
        .cand_count (cand_count),
        .found_count(found_count)
`ifdef TIMEOUT_EN
        ,
        .timeout_count(timeout_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_cand[$];
    logic [W-1:0] exp_res[$];
    bit           found_map[int];
    bit           both_mode  = 1'b0;
    bit           mute       = 1'b0;
    int           resp_delay = 3;
    int           ready_mode = 1;
    int           ready_hold = 0;
    int           last_stall = 0;
    int           vcyc       = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        checks++;
        failures++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    // Candidate i as a base-R number, digit k offset by TMIN.
    function automatic logic [W-1:0] cand_of(input int i);
        logic [W-1:0] c;
        int v;
        c = '0;
        v = i;
        for (int k = 0; k < NT; k++) begin
            c[k*8 +: 8] = 8'(TMIN + v % R);
            v = v / R;
        end
        return c;
    endfunction

    // Behavioural period checker.
    initial begin
        int run_cyc;
        run_cyc = 0;
        found   = 1'b0;
        failure = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            found   = 1'b0;
            failure = 1'b0;
            if (nlfsr_res) begin
                run_cyc = 0;
            end else if (nlfsr_ena && !mute) begin
                run_cyc++;
                if (run_cyc >= resp_delay) begin
                    if (found_map.exists(int'(co_buf))) begin
                        found   = 1'b1;
                        failure = both_mode;
                    end else begin
                        failure = 1'b1;
                    end
                end
            end
        end
    end

    // Monitor: candidate order, result handshakes, stall stability.
    initial begin
        bit           prev_nres;
        bit           stalled;
        int           stall;
        logic [W-1:0] ptaps;
        prev_nres = 1'b1;
        stalled   = 1'b0;
        stall     = 0;
        ptaps     = '0;
        res_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (res) begin
                prev_nres = 1'b1;
                stalled   = 1'b0;
                stall     = 0;
            end else begin
                if (prev_nres && !nlfsr_res) begin
                    if (exp_cand.size() == 0) fail_now("cand_extra", co_buf);
                    else chk("cand_order", co_buf, exp_cand.pop_front());
                end
                prev_nres = nlfsr_res;
                if (stalled) begin
                    chk("stall_valid", res_valid, 1);
                    chk("stall_taps", res_taps, ptaps);
                    chk("stall_nlfsr_ena", nlfsr_ena, 0);
                end
                if (res_valid && ready_hold > 0) begin
                    res_ready = 1'b0;
                    ready_hold--;
                end else if (ready_mode == 0) begin
                    res_ready = 1'($urandom_range(0, 1));
                end else begin
                    res_ready = 1'b1;
                end
                if (res_valid) vcyc++;
                if (res_valid && res_ready) begin
                    if (exp_res.size() == 0) fail_now("res_extra", res_taps);
                    else chk("res_taps", res_taps, exp_res.pop_front());
                    last_stall = stall;
                    stall      = 0;
                    stalled    = 1'b0;
                end else if (res_valid) begin
                    stalled = 1'b1;
                    ptaps   = res_taps;
                    stall++;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    task automatic wait_for(input string name, input int lim,
                            input logic [W-1:0] tap, input bit any_tap);
        int n;
        n = 0;
        while (!(nlfsr_ena && (any_tap || co_buf == tap)) && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk(name, nlfsr_ena, 1);
    endtask

    // act: 0 plain, 1 freeze+start while busy, 2 reset at 16'h0202
    task automatic sweep(input int fmode, input int act, input bit both,
                         input int rmode, input int hold);
        int nf;
        int n;
        logic [W-1:0] c;
        logic [W-1:0] sc;
        logic [CW-1:0] cc;
        logic [CW-1:0] fc;
        nf = 0;
        found_map.delete();
        exp_cand.delete();
        exp_res.delete();
        both_mode  = both;
        ready_mode = rmode;
        ready_hold = hold;
        resp_delay = $urandom_range(2, 6);
        vcyc       = 0;
        last_stall = -1;
        for (int i = 0; i < NC; i++) begin
            c = cand_of(i);
            exp_cand.push_back(c);
            if ((fmode == 1 && c == W'(16'h0203)) ||
                (fmode == 2 && $urandom_range(0, 3) == 0)) begin
                found_map[int'(c)] = 1'b1;
                exp_res.push_back(c);
                nf++;
            end
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("done_after_start", done, 0);
        if (act == 1) begin
            wait_for("freeze_reach_run", 200, '0, 1'b1);
            sc  = co_buf;
            cc  = cand_count;
            fc  = found_count;
            ena = 1'b0;
            for (int j = 0; j < 5; j++) begin
                @(negedge clk);
                start = (j == 1);
                chk("freeze_nlfsr_ena", nlfsr_ena, 0);
                chk("freeze_co_buf", co_buf, sc);
                chk("freeze_cand_count", cand_count, cc);
                chk("freeze_found_count", found_count, fc);
                chk("freeze_nlfsr_res", nlfsr_res, 0);
            end
            start = 1'b0;
            ena   = 1'b1;
            repeat (7) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (act == 2) begin
            wait_for("reach_0202", 500, W'(16'h0202), 1'b0);
            res = 1'b1;
            #1;
            chk("midres_co_buf", co_buf, W'(16'h0101));
            chk("midres_cand_count", cand_count, 0);
            chk("midres_found_count", found_count, 0);
            chk("midres_busy", busy, 0);
            chk("midres_nlfsr_res", nlfsr_res, 1);
            chk("midres_nlfsr_ena", nlfsr_ena, 0);
            @(negedge clk);
            res = 1'b0;
            exp_cand.delete();
            exp_res.delete();
            found_map.delete();
            @(negedge clk);
            chk("midres_idle_busy", busy, 0);
            chk("midres_idle_done", done, 0);
            return;
        end
        n = 0;
        while (!done && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", done, 1);
        chk("done_busy", busy, 0);
        chk("done_nlfsr_res", nlfsr_res, 1);
        chk("cand_count", cand_count, NC);
        chk("found_count", found_count, nf);
        chk("final_co_buf", co_buf, cand_of(NC - 1));
        chk("cand_left", exp_cand.size(), 0);
        chk("res_left", exp_res.size(), 0);
        if (rmode == 1) chk("valid_cycles", vcyc, nf + hold);
        if (hold > 0) chk("stall_len", last_stall, hold);
    endtask

    initial begin
        res   = 1'b1;
        ena   = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_co_buf", co_buf, W'(16'h0101));
        chk("rst_nlfsr_res", nlfsr_res, 1);
        chk("rst_nlfsr_ena", nlfsr_ena, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_taps", res_taps, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cand_count", cand_count, 0);
        chk("rst_found_count", found_count, 0);
        @(negedge clk);
        res = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);

        sweep(0, 0, 1'b0, 1, 0);
        sweep(1, 0, 1'b0, 1, 0);
        sweep(1, 0, 1'b0, 1, 20);
        sweep(1, 0, 1'b1, 1, 0);
        sweep(2, 1, 1'b0, 0, 0);
        sweep(1, 2, 1'b0, 1, 0);
        sweep(2, 0, 1'b0, 0, 0);
        for (int s = 0; s < 3; s++) begin
            sweep(2, 0, 1'($urandom_range(0, 1)), 0, 0);
        end

`ifdef TIMEOUT_EN
        chk("to_count_idle", timeout_count, 0);
        mute = 1'b1;
        sweep(0, 0, 1'b0, 1, 0);
        chk("timeout_count", timeout_count, NC);
        mute = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
